// File: rtl/munoc_wdata_downsizer_scheduler.sv
// Shares one write-data downsizer among NUM_MASTER AXI write masters: AW requests are
// round-robin granted, their burst contexts queued in order, and W bursts replayed in that order.
module munoc_wdata_downsizer_scheduler #(
  parameter  int NUM_MASTER  = 4,
  parameter  int BW_ADDR     = 32,
  parameter  int BW_DATA     = 32,
  parameter  int ORDER_DEPTH = 4,
  parameter  int BW_OFFSET   = 7,
  localparam int BW_ID       = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1,
  localparam int BW_STRB     = BW_DATA / 8
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic [NUM_MASTER-1:0]         rxawvalid,
  output logic [NUM_MASTER-1:0]         rxawready,
  input  logic [NUM_MASTER*BW_ADDR-1:0] rxawaddr,
  input  logic [NUM_MASTER*8-1:0]       rxawlen,
  input  logic [NUM_MASTER*3-1:0]       rxawsize,
  input  logic [NUM_MASTER-1:0]         rxwvalid,
  output logic [NUM_MASTER-1:0]         rxwready,
  input  logic [NUM_MASTER*BW_DATA-1:0] rxwdata,
  input  logic [NUM_MASTER*BW_STRB-1:0] rxwstrb,
  input  logic [NUM_MASTER-1:0]         rxwlast,
  output logic                          txawvalid,
  input  logic                          txawready,
  output logic [BW_ADDR-1:0]            txawaddr,
  output logic [7:0]                    txawlen,
  output logic [2:0]                    txawsize,
  output logic [BW_ID-1:0]              txawid,
  output logic                          ds_init,
  output logic [2:0]                    ds_size,
  output logic [BW_OFFSET-1:0]          ds_offset,
  output logic [7:0]                    ds_len,
  output logic                          txwvalid,
  input  logic                          txwready,
  output logic [BW_DATA-1:0]            txwdata,
  output logic [BW_STRB-1:0]            txwstrb,
  output logic                          txwlast,
  output logic                          busy
);

  localparam int BW_PTR = $clog2(ORDER_DEPTH);
  localparam logic [BW_PTR:0] DEPTH_C = ORDER_DEPTH[BW_PTR:0];
  localparam logic [BW_PTR:0] ONE_C   = {{BW_PTR{1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_DATA} w_state_e;

  typedef struct packed {
    logic [BW_ID-1:0]     idx;
    logic [2:0]           size;
    logic [BW_OFFSET-1:0] offset;
    logic [7:0]           len;
  } ctx_t;

  logic [BW_ADDR-1:0] aw_addr [NUM_MASTER];
  logic [7:0]         aw_len  [NUM_MASTER];
  logic [2:0]         aw_size [NUM_MASTER];
  logic [BW_DATA-1:0] w_data  [NUM_MASTER];
  logic [BW_STRB-1:0] w_strb  [NUM_MASTER];

  logic [BW_ID-1:0]  rr_q, rr_d, rr_grant, grant, lock_idx_q;
  logic              lock_q, lock_d, any_valid, req_valid, aw_hs;
  logic [BW_PTR:0]   wr_q, rd_q, count;
  logic [BW_PTR-1:0] rd_idx, rd_idx_nxt;
  logic              fifo_empty, fifo_full, push, pop;
  ctx_t              fifo_q [ORDER_DEPTH];
  ctx_t              push_ctx, ctx_q, ctx_d;
  w_state_e          state_q, state_d;

  always_comb begin
    for (int i = 0; i < NUM_MASTER; i++) begin
      aw_addr[i] = rxawaddr[i*BW_ADDR +: BW_ADDR];
      aw_len[i]  = rxawlen[i*8 +: 8];
      aw_size[i] = rxawsize[i*3 +: 3];
      w_data[i]  = rxwdata[i*BW_DATA +: BW_DATA];
      w_strb[i]  = rxwstrb[i*BW_STRB +: BW_STRB];
    end
  end

  assign count      = wr_q - rd_q;
  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (count == DEPTH_C);
  assign rd_idx     = rd_q[BW_PTR-1:0];
  assign rd_idx_nxt = rd_idx + BW_PTR'(1);

  // Scanning from the far end down lets the candidate closest to rr_q win last.
  always_comb begin
    logic [BW_ID-1:0] cand;
    cand      = '0;
    rr_grant  = rr_q;
    any_valid = 1'b0;
    for (int k = NUM_MASTER - 1; k >= 0; k--) begin
      cand = BW_ID'((int'(rr_q) + k) % NUM_MASTER);
      if (rxawvalid[cand]) begin
        rr_grant  = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign grant     = lock_q ? lock_idx_q : rr_grant;
  assign req_valid = lock_q ? rxawvalid[lock_idx_q] : any_valid;
  assign txawvalid = rstnn && !fifo_full && req_valid;
  assign aw_hs     = txawvalid && txawready;
  assign push      = aw_hs;
  assign lock_d    = txawvalid && !txawready;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    rxawready = '0;
    txawaddr  = '0;
    txawlen   = '0;
    txawsize  = '0;
    txawid    = '0;
    rr_d      = rr_q;
    if (txawvalid) begin
      txawaddr = aw_addr[grant];
      txawlen  = aw_len[grant];
      txawsize = aw_size[grant];
      txawid   = grant;
    end
    if (aw_hs) begin
      rxawready[grant] = 1'b1;
      rr_d = (grant == BW_ID'(NUM_MASTER - 1)) ? '0 : grant + BW_ID'(1);
    end
  end

  assign push_ctx = '{idx:    grant,
                      size:   aw_size[grant],
                      offset: aw_addr[grant][BW_OFFSET-1:0],
                      len:    aw_len[grant]};

  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    pop      = 1'b0;
    ds_init  = 1'b0;
    txwvalid = 1'b0;
    txwdata  = '0;
    txwstrb  = '0;
    txwlast  = 1'b0;
    rxwready = '0;
    unique case (state_q)
      W_IDLE: begin
        if (!fifo_empty) begin
          state_d = W_LOAD;
          ctx_d   = fifo_q[rd_idx];
        end
      end
      W_LOAD: begin
        ds_init = 1'b1;
        state_d = W_DATA;
      end
      W_DATA: begin
        txwvalid            = rxwvalid[ctx_q.idx];
        txwdata             = w_data[ctx_q.idx];
        txwstrb             = w_strb[ctx_q.idx];
        txwlast             = rxwlast[ctx_q.idx];
        rxwready[ctx_q.idx] = txwready;
        if (txwvalid && txwready && txwlast) begin
          pop = 1'b1;
          // Occupancy is taken at cycle start: an entry pushed this cycle is not yet visible.
          if (count != ONE_C) begin
            state_d = W_LOAD;
            ctx_d   = fifo_q[rd_idx_nxt];
          end else begin
            state_d = W_IDLE;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign ds_size   = ctx_q.size;
  assign ds_offset = ctx_q.offset;
  assign ds_len    = ctx_q.len;
  assign busy      = !fifo_empty || (state_q != W_IDLE);

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      state_q    <= W_IDLE;
      ctx_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= grant;
      state_q    <= state_d;
      ctx_q      <= ctx_d;
      if (push) wr_q <= wr_q + ONE_C;
      if (pop)  rd_q <= rd_q + ONE_C;
    end
  end

  // NOTE: context storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q[BW_PTR-1:0]] <= push_ctx;
  end

endmodule

// File: tb/tb_munoc_wdata_downsizer_scheduler.sv
// Directed bench for munoc_wdata_downsizer_scheduler: arbitration, lock, in-order replay,
// FIFO-full back-pressure, early-W stall and mid-burst reset.
module tb_munoc_wdata_downsizer_scheduler;

  localparam int NM = 4;
  localparam int BA = 32;
  localparam int BD = 32;
  localparam int BS = BD / 8;

  logic            clk = 1'b0;
  logic            rstnn;
  logic [NM-1:0]   rxawvalid, rxawready, rxwvalid, rxwready, rxwlast;
  logic [NM*BA-1:0] rxawaddr;
  logic [NM*8-1:0] rxawlen;
  logic [NM*3-1:0] rxawsize;
  logic [NM*BD-1:0] rxwdata;
  logic [NM*BS-1:0] rxwstrb;
  logic            txawvalid, txawready, ds_init, txwvalid, txwready, txwlast, busy;
  logic [BA-1:0]   txawaddr;
  logic [7:0]      txawlen, ds_len;
  logic [2:0]      txawsize, ds_size;
  logic [1:0]      txawid;
  logic [6:0]      ds_offset;
  logic [BD-1:0]   txwdata;
  logic [BS-1:0]   txwstrb;

  int vectors = 0;
  int miscompares = 0;

  munoc_wdata_downsizer_scheduler dut (
    .clk(clk), .rstnn(rstnn),
    .rxawvalid(rxawvalid), .rxawready(rxawready), .rxawaddr(rxawaddr),
    .rxawlen(rxawlen), .rxawsize(rxawsize),
    .rxwvalid(rxwvalid), .rxwready(rxwready), .rxwdata(rxwdata),
    .rxwstrb(rxwstrb), .rxwlast(rxwlast),
    .txawvalid(txawvalid), .txawready(txawready), .txawaddr(txawaddr),
    .txawlen(txawlen), .txawsize(txawsize), .txawid(txawid),
    .ds_init(ds_init), .ds_size(ds_size), .ds_offset(ds_offset), .ds_len(ds_len),
    .txwvalid(txwvalid), .txwready(txwready), .txwdata(txwdata),
    .txwstrb(txwstrb), .txwlast(txwlast), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_aw(input int m, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic valid);
    rxawaddr[m*BA +: BA] = addr;
    rxawlen[m*8 +: 8]    = len;
    rxawsize[m*3 +: 3]   = size;
    rxawvalid[m]         = valid;
  endtask

  task automatic set_w(input int m, input logic [31:0] data, input logic [3:0] strb,
                       input logic last, input logic valid);
    rxwdata[m*BD +: BD] = data;
    rxwstrb[m*BS +: BS] = strb;
    rxwlast[m]          = last;
    rxwvalid[m]         = valid;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      step();
      n++;
    end
    #1;
    check(tag, busy, 1'b0);
  endtask

  initial begin
    rstnn = 1'b0;
    rxawvalid = '0; rxawaddr = '0; rxawlen = '0; rxawsize = '0;
    rxwvalid = '0; rxwdata = '0; rxwstrb = '0; rxwlast = '0;
    txawready = 1'b0; txwready = 1'b0;
    repeat (3) step();
    #1;
    check("rst_awready", rxawready, 0);
    check("rst_wready", rxwready, 0);
    check("rst_awvalid", txawvalid, 0);
    check("rst_wvalid", txwvalid, 0);
    check("rst_ds_init", ds_init, 0);
    check("rst_busy", busy, 0);
    check("rst_ds", {ds_size, ds_offset, ds_len}, 0);
    check("rst_awaddr", txawaddr, 0);
    check("rst_wdata", txwdata, 0);
    rstnn = 1'b1;
    step();

    // Single master 0 burst, 4 beats; W presented before its AW is granted.
    set_aw(0, 32'h1004, 8'd3, 3'd2, 1'b1);
    txawready = 1'b1;
    set_w(0, 32'hA0, 4'hF, 1'b0, 1'b1);
    txwready = 1'b1;
    #1;
    check("t1_awvalid", txawvalid, 1);
    check("t1_awid", txawid, 0);
    check("t1_awaddr", txawaddr, 32'h1004);
    check("t1_awlen", txawlen, 3);
    check("t1_awready", rxawready, 4'b0001);
    check("t1_early_wready", rxwready, 0);
    step();
    set_aw(0, 32'h0, 8'd0, 3'd0, 1'b0);
    #1;
    check("t1_busy", busy, 1);
    check("t1_no_init_yet", ds_init, 0);
    check("t1_wready_held", rxwready, 0);
    step();
    #1;
    check("t1_ds_init", ds_init, 1);
    check("t1_ds_offset", ds_offset, 7'h04);
    check("t1_ds_len", ds_len, 3);
    check("t1_ds_size", ds_size, 2);
    check("t1_load_wvalid", txwvalid, 0);
    step();
    for (int b = 0; b < 4; b++) begin
      set_w(0, 32'hA0 + b, 4'hF, (b == 3), 1'b1);
      #1;
      check($sformatf("t1_beat%0d_valid", b), txwvalid, 1);
      check($sformatf("t1_beat%0d_data", b), txwdata, 32'hA0 + b);
      check($sformatf("t1_beat%0d_last", b), txwlast, (b == 3));
      check($sformatf("t1_beat%0d_wready", b), rxwready, 4'b0001);
      check($sformatf("t1_beat%0d_init", b), ds_init, 0);
      check($sformatf("t1_beat%0d_offset", b), ds_offset, 7'h04);
      step();
    end
    set_w(0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t1_busy_done", busy, 0);
    check("t1_wvalid_done", txwvalid, 0);

    // Masters 1 and 2 together: grant 1 then 2, replay in order.
    step();
    set_aw(1, 32'h2010, 8'd0, 3'd2, 1'b1);
    set_aw(2, 32'h3020, 8'd0, 3'd1, 1'b1);
    set_w(1, 32'h11, 4'hF, 1'b1, 1'b1);
    set_w(2, 32'h22, 4'h3, 1'b1, 1'b1);
    #1;
    check("t2_id_first", txawid, 1);
    check("t2_addr_first", txawaddr, 32'h2010);
    check("t2_awready_first", rxawready, 4'b0010);
    check("t2_wready_idle", rxwready, 0);
    step();
    set_aw(1, 32'h0, 8'd0, 3'd0, 1'b0);
    #1;
    check("t2_id_second", txawid, 2);
    check("t2_addr_second", txawaddr, 32'h3020);
    check("t2_size_second", txawsize, 1);
    check("t2_awready_second", rxawready, 4'b0100);
    step();
    set_aw(2, 32'h0, 8'd0, 3'd0, 1'b0);
    #1;
    check("t2_init1", ds_init, 1);
    check("t2_offset1", ds_offset, 7'h10);
    check("t2_size1", ds_size, 2);
    step();
    #1;
    check("t2_w1_valid", txwvalid, 1);
    check("t2_w1_data", txwdata, 32'h11);
    check("t2_w1_last", txwlast, 1);
    check("t2_w1_wready", rxwready, 4'b0010);
    step();
    set_w(1, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t2_init2", ds_init, 1);
    check("t2_offset2", ds_offset, 7'h20);
    check("t2_size2", ds_size, 1);
    check("t2_bubble_wready", rxwready, 0);
    step();
    #1;
    check("t2_w2_data", txwdata, 32'h22);
    check("t2_w2_strb", txwstrb, 4'h3);
    check("t2_w2_wready", rxwready, 4'b0100);
    step();
    set_w(2, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t2_busy_done", busy, 0);

    // Pointer now 3: master 0 granted alone, then stays locked while master 3 arrives.
    step();
    txawready = 1'b0;
    set_aw(0, 32'h5000, 8'd0, 3'd2, 1'b1);
    #1;
    check("t3_id_initial", txawid, 0);
    check("t3_awvalid", txawvalid, 1);
    check("t3_awready_low", rxawready, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      set_aw(3, 32'h4000, 8'd0, 3'd2, 1'b1);
      #1;
      check($sformatf("t3_locked_id%0d", c), txawid, 0);
      check($sformatf("t3_locked_addr%0d", c), txawaddr, 32'h5000);
    end
    txawready = 1'b1;
    #1;
    check("t3_release_awready", rxawready, 4'b0001);
    step();
    set_aw(0, 32'h0, 8'd0, 3'd0, 1'b0);
    #1;
    check("t3_next_id", txawid, 3);
    check("t3_next_awready", rxawready, 4'b1000);
    step();
    set_aw(3, 32'h0, 8'd0, 3'd0, 1'b0);
    set_w(0, 32'h33, 4'hF, 1'b1, 1'b1);
    set_w(3, 32'h44, 4'hF, 1'b1, 1'b1);
    wait_idle(20, "t3_drain");
    set_w(0, 32'h0, 4'h0, 1'b0, 1'b0);
    set_w(3, 32'h0, 4'h0, 1'b0, 1'b0);

    // Fill the FIFO with txwready low; the fifth AW waits for the first pop.
    step();
    txwready = 1'b0;
    txawready = 1'b1;
    set_aw(1, 32'h7000, 8'd0, 3'd2, 1'b1);
    set_w(1, 32'h77, 4'hF, 1'b1, 1'b1);
    #1;
    check("t4_push0", rxawready, 4'b0010);
    for (int i = 1; i < 4; i++) begin
      step();
      #1;
      check($sformatf("t4_push%0d", i), rxawready, 4'b0010);
    end
    step();
    #1;
    check("t4_full_awready", rxawready, 0);
    check("t4_full_awvalid", txawvalid, 0);
    check("t4_full_wvalid", txwvalid, 1);
    step();
    #1;
    check("t4_still_full", rxawready, 0);
    txwready = 1'b1;
    #1;
    check("t4_no_bypass", rxawready, 0);
    check("t4_pop_wready", rxwready, 4'b0010);
    step();
    txwready = 1'b0;
    #1;
    check("t4_admit_awready", rxawready, 4'b0010);
    check("t4_admit_awvalid", txawvalid, 1);
    check("t4_reload", ds_init, 1);
    step();
    set_aw(1, 32'h0, 8'd0, 3'd0, 1'b0);
    txwready = 1'b1;
    wait_idle(40, "t4_drain");
    set_w(1, 32'h0, 4'h0, 1'b0, 1'b0);

    // Master 2 drives W early, then a len=7 burst is cut by reset on beat 2.
    step();
    set_w(2, 32'h50, 4'hF, 1'b0, 1'b1);
    #1;
    check("t5_early_wready", rxwready, 0);
    check("t5_early_wvalid", txwvalid, 0);
    step();
    set_aw(2, 32'h6008, 8'd7, 3'd2, 1'b1);
    #1;
    check("t5_awid", txawid, 2);
    check("t5_awready", rxawready, 4'b0100);
    check("t5_wready_pre", rxwready, 0);
    step();
    set_aw(2, 32'h0, 8'd0, 3'd0, 1'b0);
    #1;
    check("t5_wready_queued", rxwready, 0);
    step();
    #1;
    check("t5_init", ds_init, 1);
    check("t5_len", ds_len, 7);
    check("t5_offset", ds_offset, 7'h08);
    check("t5_wready_load", rxwready, 0);
    step();
    for (int b = 0; b < 2; b++) begin
      set_w(2, 32'h50 + b, 4'hF, 1'b0, 1'b1);
      #1;
      check($sformatf("t5_beat%0d_data", b), txwdata, 32'h50 + b);
      check($sformatf("t5_beat%0d_wready", b), rxwready, 4'b0100);
      step();
    end
    set_w(2, 32'h52, 4'hF, 1'b0, 1'b1);
    rstnn = 1'b0;
    #1;
    check("t6_beat2_data", txwdata, 32'h52);
    step();
    #1;
    check("t6_wvalid", txwvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_wready", rxwready, 0);
    check("t6_ds_init", ds_init, 0);
    check("t6_ds_len", ds_len, 0);
    check("t6_awvalid", txawvalid, 0);
    rstnn = 1'b1;
    step();
    step();
    #1;
    check("t6_fifo_empty_busy", busy, 0);
    check("t6_fifo_empty_init", ds_init, 0);
    check("t6_fifo_empty_wready", rxwready, 0);
    set_w(2, 32'h0, 4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
